alarm_debounce: RTL and testbench

- Sits directly downstream of the region comparator. Consumes its 3-bit polarity-encoded alarm_io (inner/middle/outer zone) and produces the debounced, fail-safe zone outputs that drive the external NPN/PNP transistor stage.
- Per zone: N consecutive alarmed scans are required to assert, and M consecutive clean scans plus a minimum hold time are required to release.
- A scan watchdog forces all zones into alarm if scans stop arriving.

---
 rtl/alarm_debounce_pkg.sv | 22 ++
 rtl/alarm_debounce_chan_fsm.sv | 107 ++++++++++
 rtl/alarm_debounce.sv | 108 ++++++++++
 tb/tb_alarm_debounce.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_debounce_pkg.sv
// Shared types and constants for the zone alarm debouncer.
package alarm_debounce_pkg;

  localparam int         NUM_ZONES      = 3;
  localparam logic [1:0] HW_NPN         = 2'd1;
  localparam int         DEF_SAMPLE_DLY = 4;
  localparam int         DEF_MS_DIV     = 100000;
  localparam int         DEF_WDOG_MS    = 500;

  typedef enum logic [3:0] {
    ST_SAFE      = 4'b0001,
    ST_ARMING    = 4'b0010,
    ST_ALARM     = 4'b0100,
    ST_RELEASING = 4'b1000
  } chan_state_e;

  // A programmed scan count of zero means "one scan".
  function automatic logic [3:0] eff_scans(input logic [3:0] n);
    return (n == 4'd0) ? 4'd1 : n;
  endfunction

endpackage

// File: rtl/alarm_debounce_chan_fsm.sv
// One zone's assert/release debounce: N alarmed scans to assert, M clean scans plus hold time to release.
module alarm_chan_fsm
  import alarm_debounce_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stb,
  input  logic        a,
  input  logic        tick,
  input  logic [3:0]  eff_set,
  input  logic [3:0]  eff_clr,
  input  logic [15:0] hold_ms,
  input  logic        force_alarm,
  output logic        state_alarm
);

  chan_state_e state_q, state_d;
  logic [3:0]  sc_q, sc_d;
  logic [15:0] hc_q, hc_d;
  logic [4:0]  sc_inc;

  assign sc_inc      = {1'b0, sc_q} + 5'd1;
  assign state_alarm = (state_q == ST_ALARM) || (state_q == ST_RELEASING);

  // NOTE: every variable gets its default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    hc_d    = hc_q;

    if (state_alarm && tick && (hc_q != 16'd0)) hc_d = hc_q - 16'd1;

    if (force_alarm) begin
      state_d = ST_ALARM;
      hc_d    = hold_ms;
      sc_d    = 4'd0;
    end else begin
      case (state_q)
        ST_SAFE: begin
          if (stb && a) begin
            if (eff_set == 4'd1) begin
              state_d = ST_ALARM;
              hc_d    = hold_ms;
              sc_d    = 4'd0;
            end else begin
              state_d = ST_ARMING;
              sc_d    = 4'd1;
            end
          end
        end
        ST_ARMING: begin
          if (stb && a) begin
            if (sc_inc >= {1'b0, eff_set}) begin
              state_d = ST_ALARM;
              hc_d    = hold_ms;
              sc_d    = 4'd0;
            end else begin
              sc_d = sc_inc[3:0];
            end
          end else if (stb) begin
            state_d = ST_SAFE;
            sc_d    = 4'd0;
          end
        end
        ST_ALARM: begin
          if (stb && !a) begin
            state_d = ST_RELEASING;
            sc_d    = 4'd1;
          end
        end
        ST_RELEASING: begin
          // An alarmed scan beats a simultaneous hold expiry.
          if (stb && a) begin
            state_d = ST_ALARM;
            hc_d    = hold_ms;
            sc_d    = 4'd0;
          end else begin
            if (stb && (sc_q != 4'hF)) sc_d = sc_inc[3:0];
            if ((sc_q >= eff_clr) && (hc_q == 16'd0)) begin
              state_d = ST_SAFE;
              sc_d    = 4'd0;
            end
          end
        end
        default: begin
          state_d = ST_SAFE;
          sc_d    = 4'd0;
          hc_d    = 16'd0;
        end
      endcase
    end
  end

  // NOTE: reset is synchronous, sampled on the clock edge like any other input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_SAFE;
      sc_q    <= 4'd0;
      hc_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      hc_q    <= hc_d;
    end
  end

endmodule

// File: rtl/alarm_debounce.sv
// Debounces the comparator's three zone alarms and drives the fail-safe transistor-stage outputs.
module alarm_debounce
  import alarm_debounce_pkg::*;
#(
  parameter int SAMPLE_DLY = DEF_SAMPLE_DLY,
  parameter int MS_DIV     = DEF_MS_DIV,
  parameter int WDOG_MS    = DEF_WDOG_MS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           hw_type,
  input  logic                 cycle_enable,
  input  logic [NUM_ZONES-1:0] alarm_in,
  input  logic [3:0]           set_scans,
  input  logic [3:0]           clr_scans,
  input  logic [15:0]          hold_ms,
  output logic [NUM_ZONES-1:0] alarm_state,
  output logic [NUM_ZONES-1:0] alarm_out,
  output logic                 wdog_fault
);

  localparam int DW = (SAMPLE_DLY > 1) ? $clog2(SAMPLE_DLY) : 1;
  localparam int PW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam int WW = $clog2(WDOG_MS + 1);

  localparam logic [DW-1:0] DLY_LOAD = DW'(SAMPLE_DLY - 1);
  localparam logic [PW-1:0] PRE_MAX  = PW'(MS_DIV - 1);
  localparam logic [WW-1:0] WD_MAX   = WW'(WDOG_MS);

  logic [1:0]           ce_q, ce_d;
  logic [DW-1:0]        dly_q, dly_d;
  logic                 busy_q, busy_d;
  logic [PW-1:0]        pre_q, pre_d;
  logic [WW-1:0]        wd_q, wd_d;
  logic [NUM_ZONES-1:0] out_q, out_d;

  logic                 fall, stb, tick, npn, force_alarm;
  logic [3:0]           eff_set, eff_clr;
  logic [NUM_ZONES-1:0] norm;

  assign npn         = (hw_type == HW_NPN);
  assign fall        = (ce_q == 2'b10);
  // A fall landing on the strobe cycle restarts the delay instead of strobing twice.
  assign stb         = busy_q && (dly_q == '0) && !fall;
  assign tick        = (pre_q == PRE_MAX);
  assign wdog_fault  = (wd_q == WD_MAX);
  assign force_alarm = wdog_fault && !stb;
  assign norm        = alarm_in ^ {NUM_ZONES{npn}};
  assign eff_set     = eff_scans(set_scans);
  assign eff_clr     = eff_scans(clr_scans);
  assign alarm_out   = out_q;

  always_comb begin
    ce_d   = {ce_q[0], cycle_enable};
    dly_d  = dly_q;
    busy_d = busy_q;
    if (fall) begin
      dly_d  = DLY_LOAD;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (dly_q == '0) busy_d = 1'b0;
      else             dly_d  = dly_q - 1'b1;
    end

    pre_d = tick ? '0 : pre_q + 1'b1;

    wd_d = wd_q;
    if (stb)                            wd_d = '0;
    else if (tick && (wd_q != WD_MAX))  wd_d = wd_q + 1'b1;

    out_d = alarm_state ^ {NUM_ZONES{npn}};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ce_q   <= 2'b00;
      dly_q  <= '0;
      busy_q <= 1'b0;
      pre_q  <= '0;
      wd_q   <= '0;
      out_q  <= {NUM_ZONES{npn}};
    end else begin
      ce_q   <= ce_d;
      dly_q  <= dly_d;
      busy_q <= busy_d;
      pre_q  <= pre_d;
      wd_q   <= wd_d;
      out_q  <= out_d;
    end
  end

  for (genvar z = 0; z < NUM_ZONES; z++) begin : g_zone
    alarm_chan_fsm u_fsm (
      .clk         (clk),
      .rst_n       (rst_n),
      .stb         (stb),
      .a           (norm[z]),
      .tick        (tick),
      .eff_set     (eff_set),
      .eff_clr     (eff_clr),
      .hold_ms     (hold_ms),
      .force_alarm (force_alarm),
      .state_alarm (alarm_state[z])
    );
  end

endmodule

// File: tb/tb_alarm_debounce.sv
// Directed bench for alarm_debounce with a 10-clk ms tick and a 3 ms scan watchdog.
module tb_alarm_debounce;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  hw_type;
  logic        cycle_enable;
  logic [2:0]  alarm_in;
  logic [3:0]  set_scans;
  logic [3:0]  clr_scans;
  logic [15:0] hold_ms;
  logic [2:0]  alarm_state;
  logic [2:0]  alarm_out;
  logic        wdog_fault;

  int n_checks = 0;
  int n_fail   = 0;

  alarm_debounce #(.SAMPLE_DLY(4), .MS_DIV(10), .WDOG_MS(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hw_type      (hw_type),
    .cycle_enable (cycle_enable),
    .alarm_in     (alarm_in),
    .set_scans    (set_scans),
    .clr_scans    (clr_scans),
    .hold_ms      (hold_ms),
    .alarm_state  (alarm_state),
    .alarm_out    (alarm_out),
    .wdog_fault   (wdog_fault)
  );

  always #5 clk = ~clk;

  // One scan: 6 clks high, fall, then 8 clks low so alarm_in is stable across the strobe.
  // Enters and leaves 1 time unit after a rising edge.
  task automatic scan(input logic [2:0] val);
    alarm_in     = val;
    cycle_enable = 1'b1;
    repeat (6) @(posedge clk);
    #1 cycle_enable = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; hw_type = 2'd1; cycle_enable = 1'b0; alarm_in = 3'b000;
    set_scans = 4'd1; clr_scans = 4'd1; hold_ms = 16'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (alarm_out !== 3'b111) begin n_fail++; $display("FAIL reset_out_npn: got %b expected 111", alarm_out); end
    n_checks++;
    if (alarm_state !== 3'b000) begin n_fail++; $display("FAIL reset_state: got %b expected 000", alarm_state); end
    n_checks++;
    if (wdog_fault !== 1'b0) begin n_fail++; $display("FAIL reset_wdog: got %b expected 0", wdog_fault); end
    hw_type = 2'd0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (alarm_out !== 3'b000) begin n_fail++; $display("FAIL reset_out_pnp: got %b expected 000", alarm_out); end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_arming;
    hw_type = 2'd0; set_scans = 4'd3; clr_scans = 4'd1; hold_ms = 16'd0;
    scan(3'b001);
    scan(3'b001);
    n_checks++;
    if (alarm_state !== 3'b000) begin n_fail++; $display("FAIL arm_two_scans: got %b expected 000", alarm_state); end
    scan(3'b000);
    n_checks++;
    if (alarm_state !== 3'b000) begin n_fail++; $display("FAIL arm_broken: got %b expected 000", alarm_state); end
    scan(3'b001);
    scan(3'b001);
    alarm_in     = 3'b001;
    cycle_enable = 1'b1;
    repeat (6) @(posedge clk);
    #1 cycle_enable = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (alarm_state !== 3'b000) begin n_fail++; $display("FAIL arm_early: got %b expected 000", alarm_state); end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (alarm_state !== 3'b001) begin n_fail++; $display("FAIL arm_latency: got %b expected 001", alarm_state); end
    n_checks++;
    if (alarm_out !== 3'b000) begin n_fail++; $display("FAIL out_early: got %b expected 000", alarm_out); end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (alarm_out !== 3'b001) begin n_fail++; $display("FAIL out_latency: got %b expected 001", alarm_out); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_hold_time;
    int  n;
    bit  seen;
    scan(3'b000);
    n_checks++;
    if (alarm_state !== 3'b000) begin n_fail++; $display("FAIL hold_pre_release: got %b expected 000", alarm_state); end
    set_scans = 4'd1; clr_scans = 4'd2; hold_ms = 16'd5;
    n    = 0;
    seen = 1'b0;
    fork
      begin
        scan(3'b001);
        repeat (5) scan(3'b000);
      end
      begin
        for (int i = 0; i < 40 && !seen; i++) begin
          @(negedge clk);
          if (alarm_state[0] === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL hold_entry: got no alarm within 40 clks expected alarm"); end
        while (seen && alarm_state[0] === 1'b1 && n < 100) begin
          @(negedge clk);
          n++;
        end
        n_checks++;
        if (n < 40 || n > 60) begin n_fail++; $display("FAIL hold_duration: got %0d clks expected 40..60", n); end
      end
    join
    n_checks++;
    if (alarm_state !== 3'b000) begin n_fail++; $display("FAIL hold_after: got %b expected 000", alarm_state); end
  endtask

  task automatic test_reentry;
    set_scans = 4'd1; clr_scans = 4'd4; hold_ms = 16'd0;
    scan(3'b001);
    scan(3'b000);
    scan(3'b000);
    n_checks++;
    if (alarm_state !== 3'b001) begin n_fail++; $display("FAIL releasing_held: got %b expected 001", alarm_state); end
    scan(3'b001);
    n_checks++;
    if (alarm_state !== 3'b001) begin n_fail++; $display("FAIL reentry: got %b expected 001", alarm_state); end
    repeat (3) scan(3'b000);
    n_checks++;
    if (alarm_state !== 3'b001) begin n_fail++; $display("FAIL three_clean: got %b expected 001", alarm_state); end
    scan(3'b000);
    n_checks++;
    if (alarm_state !== 3'b000) begin n_fail++; $display("FAIL fourth_clean: got %b expected 000", alarm_state); end
  endtask

  task automatic test_watchdog;
    hw_type = 2'd1; alarm_in = 3'b111; cycle_enable = 1'b0;
    clr_scans = 4'd1; hold_ms = 16'd0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (wdog_fault !== 1'b0) begin n_fail++; $display("FAIL wdog_early: got %b expected 0", wdog_fault); end
    repeat (35) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (wdog_fault !== 1'b1) begin n_fail++; $display("FAIL wdog_set: got %b expected 1", wdog_fault); end
    n_checks++;
    if (alarm_state !== 3'b111) begin n_fail++; $display("FAIL wdog_state: got %b expected 111", alarm_state); end
    n_checks++;
    if (alarm_out !== 3'b000) begin n_fail++; $display("FAIL wdog_out: got %b expected 000", alarm_out); end
    @(posedge clk);
    #1 cycle_enable = 1'b1;
    repeat (6) @(posedge clk);
    #1 cycle_enable = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (wdog_fault !== 1'b1) begin n_fail++; $display("FAIL wdog_before_stb: got %b expected 1", wdog_fault); end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (wdog_fault !== 1'b0) begin n_fail++; $display("FAIL wdog_clear: got %b expected 0", wdog_fault); end
    n_checks++;
    if (alarm_state !== 3'b111) begin n_fail++; $display("FAIL wdog_releasing: got %b expected 111", alarm_state); end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (alarm_state !== 3'b000) begin n_fail++; $display("FAIL wdog_release: got %b expected 000", alarm_state); end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (alarm_out !== 3'b111) begin n_fail++; $display("FAIL wdog_out_release: got %b expected 111", alarm_out); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_zero_scans;
    hw_type = 2'd1; set_scans = 4'd0; clr_scans = 4'd0; hold_ms = 16'd0;
    scan(3'b110);
    n_checks++;
    if (alarm_state !== 3'b001) begin n_fail++; $display("FAIL zero_set_state: got %b expected 001", alarm_state); end
    n_checks++;
    if (alarm_out !== 3'b110) begin n_fail++; $display("FAIL zero_set_out: got %b expected 110", alarm_out); end
    scan(3'b111);
    n_checks++;
    if (alarm_state !== 3'b000) begin n_fail++; $display("FAIL zero_clr_state: got %b expected 000", alarm_state); end
    n_checks++;
    if (alarm_out !== 3'b111) begin n_fail++; $display("FAIL zero_clr_out: got %b expected 111", alarm_out); end
    hw_type = 2'd0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (alarm_out !== 3'b000) begin n_fail++; $display("FAIL hw_switch_out: got %b expected 000", alarm_out); end
    n_checks++;
    if (alarm_state !== 3'b000) begin n_fail++; $display("FAIL hw_switch_state: got %b expected 000", alarm_state); end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_arming;
    test_hold_time;
    test_reentry;
    test_watchdog;
    test_zero_scans;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
